// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + IDLE/EXEC/RESP sequencer in front of an external combinational 4-bit ALU.
// Optional sticky {ovf, carry} flags are enabled with `define ALU_CTRL_STICKY_EN.
module alu_cmd_sequencer #(
  parameter int unsigned CMD_DEPTH = 2,
  parameter logic [3:0]  ACC_INIT  = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_sel,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_res,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  input  logic       alu_zero,
  input  logic       alu_sign,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic [3:0] acc,
  output logic       busy,
  input  logic       sticky_clr,
  output logic [1:0] sticky_flags
);
  localparam int unsigned AW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  cmd_t        fifo_q [CMD_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  state_e      state_q, state_d;
  logic [3:0]  alu_a_q, alu_b_q, rsp_data_q, rsp_flags_q, acc_q;
  logic [2:0]  alu_sel_q;
  logic        rsp_valid_q;
  logic        empty, full, push, pop, capture;
  cmd_t        head;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign head  = fifo_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        pop     = !empty;
        state_d = empty ? IDLE : EXEC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
      acc_q       <= ACC_INIT;
    end else begin
      state_q <= state_d;
      // acc is sampled here, before any capture, so chaining sees the previous result.
      if (pop) begin
        alu_sel_q <= head.sel;
        alu_b_q   <= head.b;
        alu_a_q   <= head.use_acc ? acc_q : head.a;
      end
      if (capture) begin
        rsp_data_q  <= alu_res;
        rsp_flags_q <= {alu_sign, alu_zero, alu_ovf, alu_carry};
        acc_q       <= alu_res;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_CTRL_STICKY_EN
  logic [1:0] sticky_q;

  // A clear coinciding with a capture keeps only the new capture's events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sticky_q <= 2'b00;
    else if (capture)    sticky_q <= (sticky_clr ? 2'b00 : sticky_q) | {alu_ovf, alu_carry};
    else if (sticky_clr) sticky_q <= 2'b00;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 2'b00;
`endif

  assign cmd_ready = !full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign acc       = acc_q;
  assign busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised bench for alu_cmd_sequencer: behavioural ALU plus an in-order scoreboard queue.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_res;
  logic       alu_carry, alu_ovf, alu_zero, alu_sign;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_data, rsp_flags, acc;
  logic       busy, sticky_clr = 1'b0;
  logic [1:0] sticky_flags;

  int n_chk = 0, n_pass = 0;

  alu_cmd_sequencer #(.CMD_DEPTH(2), .ACC_INIT(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .acc(acc), .busy(busy),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  // Returns {sign, zero, ovf, carry, result}.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    logic [4:0] s;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (sel)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[4]; v = (a[3] == b[3]) && (s[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; c = s[4]; v = (a[3] != b[3]) && (s[3] != a[3]); end
      3'd2: s[3:0] = a & b;
      3'd3: s[3:0] = a | b;
      3'd4: s[3:0] = a ^ b;
      3'd5: s[3:0] = ~a;
      3'd6: begin s[3:0] = {a[2:0], 1'b0}; c = a[3]; end
      default: begin s[3:0] = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {s[3], (s[3:0] == 4'h0), v, c, s[3:0]};
  endfunction

  logic [7:0] alu_out;
  always_comb alu_out = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_res = alu_out[3:0];
  assign {alu_sign, alu_zero, alu_ovf, alu_carry} = alu_out[7:4];

  typedef struct {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] out;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] m_acc = 4'h0;

  // Responses come back in push order, so the effective operand is resolved at push time.
  task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel, input logic use_acc);
    exp_t e;
    e.sel = sel;
    e.b   = b;
    e.a   = use_acc ? m_acc : a;
    e.out = alu_fn(e.a, b, sel);
    m_acc = e.out[3:0];
    expq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
    expq.delete();
    m_acc = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%0h exp=1", cmd_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (acc !== 4'h0) $display("FAIL reset_acc got=%0h exp=0", acc); else n_pass++;
    n_chk++; if ({alu_sel, alu_a, alu_b} !== 11'h0) $display("FAIL reset_alu_regs got=%0h exp=0", {alu_sel, alu_a, alu_b}); else n_pass++;
    n_chk++; if ({rsp_flags, rsp_data} !== 8'h0) $display("FAIL reset_rsp got=%0h exp=0", {rsp_flags, rsp_data}); else n_pass++;
    n_chk++; if (sticky_flags !== 2'b00) $display("FAIL reset_sticky got=%0h exp=0", sticky_flags); else n_pass++;
  endtask

  task automatic test_single();
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'h7; cmd_b = 4'h9; cmd_use_acc = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy got=%0h exp=1", busy); else n_pass++;
    @(negedge clk);
    n_chk++; if ({alu_a, alu_b} !== 8'h79) $display("FAIL single_alu_ab got=%0h exp=79", {alu_a, alu_b}); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%0h exp=0", rsp_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got=%0h exp=1", rsp_valid); else n_pass++;
    n_chk++; if (rsp_data !== 4'h0) $display("FAIL single_data got=%0h exp=0", rsp_data); else n_pass++;
    n_chk++; if (rsp_flags !== 4'b0101) $display("FAIL single_flags got=%b exp=0101", rsp_flags); else n_pass++;
    n_chk++; if (acc !== 4'h0) $display("FAIL single_acc got=%0h exp=0", acc); else n_pass++;
    @(negedge clk);
    n_chk++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done got=%b exp=00", {rsp_valid, busy}); else n_pass++;
    m_acc = 4'h0;
  endtask

  task automatic test_chain();
    int got = 0;
    exp_t e;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'h3; cmd_b = 4'h4; cmd_use_acc = 1'b0;
    model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
    @(negedge clk);
    cmd_a = 4'hE; cmd_b = 4'h1; cmd_use_acc = 1'b1;
    model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      if (rsp_valid) begin
        e = expq.pop_front();
        if (got == 0) begin
          n_chk++; if (rsp_data !== 4'h7) $display("FAIL chain_rsp1 got=%0h exp=7", rsp_data); else n_pass++;
        end else begin
          n_chk++; if (alu_a !== 4'h7) $display("FAIL chain_alu_a got=%0h exp=7", alu_a); else n_pass++;
          n_chk++; if (rsp_data !== 4'h8) $display("FAIL chain_rsp2 got=%0h exp=8", rsp_data); else n_pass++;
          n_chk++; if (acc !== 4'h8) $display("FAIL chain_acc got=%0h exp=8", acc); else n_pass++;
        end
        n_chk++; if ({rsp_flags, rsp_data} !== e.out) $display("FAIL chain_model got=%0h exp=%0h", {rsp_flags, rsp_data}, e.out); else n_pass++;
        got++;
      end
      @(negedge clk);
    end
    n_chk++; if (got !== 2) $display("FAIL chain_count got=%0d exp=2", got); else n_pass++;
  endtask

  // Random stream with hold-until-accepted commands; rdy_pct=100 also checks the 2-cycle rate.
  task automatic test_stream(input string nm, input int n, input int vld_pct, input int rdy_pct);
    int sent = 0, got = 0, cyc = 0, last = 0;
    bit acc_c;
    exp_t e;
    cmd_valid = 1'b0;
    while ((sent < n || got < n) && cyc < 2000) begin
      if (!cmd_valid && sent < n && $urandom_range(99) < vld_pct) begin
        cmd_valid = 1'b1;
        cmd_sel = 3'($urandom_range(7)); cmd_a = 4'($urandom_range(15));
        cmd_b = 4'($urandom_range(15)); cmd_use_acc = 1'($urandom_range(1));
      end
      rsp_ready = ($urandom_range(99) < rdy_pct);
      acc_c = cmd_valid && cmd_ready;
      if (acc_c) begin
        model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
        sent++;
      end
      if (rsp_valid && rsp_ready) begin
        if (expq.size() == 0) begin
          n_chk++; $display("FAIL %s_unexpected rsp=%0h exp=none", nm, rsp_data);
        end else begin
          e = expq.pop_front();
          n_chk++; if ({rsp_flags, rsp_data} !== e.out) $display("FAIL %s_rsp got=%0h exp=%0h", nm, {rsp_flags, rsp_data}, e.out); else n_pass++;
          n_chk++; if ({alu_sel, alu_a, alu_b} !== {e.sel, e.a, e.b}) $display("FAIL %s_operands got=%0h exp=%0h", nm, {alu_sel, alu_a, alu_b}, {e.sel, e.a, e.b}); else n_pass++;
          n_chk++; if (acc !== e.out[3:0]) $display("FAIL %s_acc got=%0h exp=%0h", nm, acc, e.out[3:0]); else n_pass++;
          if (rdy_pct == 100 && got > 0) begin
            n_chk++; if (cyc - last != 2) $display("FAIL %s_rate got=%0d exp=2", nm, cyc - last); else n_pass++;
          end
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc_c) cmd_valid = 1'b0;
    end
    n_chk++; if (got !== n) $display("FAIL %s_count got=%0d exp=%0d", nm, got, n); else n_pass++;
  endtask

  task automatic test_backpressure();
    int got = 0, cyc = 0, last = 0;
    bit acc_c;
    logic [3:0] held;
    exp_t e;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_sel = 3'($urandom_range(7)); cmd_a = 4'($urandom_range(15));
      cmd_b = 4'($urandom_range(15)); cmd_use_acc = 1'($urandom_range(1));
      n_chk++; if (cmd_ready !== 1'b1) $display("FAIL bp_fill_ready k=%0d got=%0h exp=1", k, cmd_ready); else n_pass++;
      model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
      @(negedge clk);
    end
    cmd_sel = 3'd0; cmd_a = 4'h5; cmd_b = 4'hA; cmd_use_acc = 1'b0;
    held = rsp_data;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (cmd_ready !== 1'b0) $display("FAIL bp_full_ready got=%0h exp=0", cmd_ready); else n_pass++;
      n_chk++; if ({rsp_valid, rsp_data} !== {1'b1, expq[0].out[3:0]}) $display("FAIL bp_hold got=%0h exp=%0h", {rsp_valid, rsp_data}, {1'b1, expq[0].out[3:0]}); else n_pass++;
      n_chk++; if (rsp_data !== held) $display("FAIL bp_stable got=%0h exp=%0h", rsp_data, held); else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    while (got < 4 && cyc < 40) begin
      acc_c = cmd_valid && cmd_ready;
      if (acc_c) model_push(cmd_a, cmd_b, cmd_sel, cmd_use_acc);
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          n_chk++; $display("FAIL bp_unexpected rsp=%0h exp=none", rsp_data);
        end else begin
          e = expq.pop_front();
          n_chk++; if ({rsp_flags, rsp_data} !== e.out) $display("FAIL bp_rsp got=%0h exp=%0h", {rsp_flags, rsp_data}, e.out); else n_pass++;
          if (got > 0) begin
            n_chk++; if (cyc - last != 2) $display("FAIL bp_rate got=%0d exp=2", cyc - last); else n_pass++;
          end
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc_c) cmd_valid = 1'b0;
    end
    n_chk++; if (got !== 4) $display("FAIL bp_count got=%0d exp=4", got); else n_pass++;
    n_chk++; if (expq.size() !== 0) $display("FAIL bp_leftover got=%0d exp=0", expq.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_use_acc = 1'b0; cmd_sel = 3'd0;
    cmd_a = 4'h5; cmd_b = 4'h0; @(negedge clk);
    cmd_a = 4'h1; cmd_b = 4'h1; @(negedge clk);
    cmd_a = 4'h2; cmd_b = 4'h2; @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++; if ({rsp_valid, cmd_ready, acc} !== {1'b1, 1'b0, 4'h5}) $display("FAIL rmid_pre got=%0h exp=%0h", {rsp_valid, cmd_ready, acc}, {1'b1, 1'b0, 4'h5}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rmid_valid got=%0h exp=0", rsp_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if (acc !== 4'h0) $display("FAIL rmid_acc got=%0h exp=0", acc); else n_pass++;
    expq.delete();
    m_acc = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL rmid_no_rsp got=%0h exp=0", seen); else n_pass++;
  endtask

  task automatic test_sticky();
    logic [1:0] exp1, exp2, exp3;
`ifdef ALU_CTRL_STICKY_EN
    exp1 = 2'b10; exp2 = 2'b01; exp3 = 2'b00;
`else
    exp1 = 2'b00; exp2 = 2'b00; exp3 = 2'b00;
`endif
    rsp_ready = 1'b1; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'h7; cmd_b = 4'h1;
    @(negedge clk); cmd_valid = 1'b0; @(negedge clk); @(negedge clk);
    n_chk++; if (sticky_flags !== exp1) $display("FAIL sticky_ovf got=%b exp=%b", sticky_flags, exp1); else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 3'd2; cmd_a = 4'h1; cmd_b = 4'h1;
    @(negedge clk); cmd_valid = 1'b0; @(negedge clk); @(negedge clk);
    n_chk++; if (sticky_flags !== exp1) $display("FAIL sticky_persist got=%b exp=%b", sticky_flags, exp1); else n_pass++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'hF; cmd_b = 4'h1;
    @(negedge clk); cmd_valid = 1'b0; @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk); sticky_clr = 1'b0;
    n_chk++; if (sticky_flags !== exp2) $display("FAIL sticky_clr_capture got=%b exp=%b", sticky_flags, exp2); else n_pass++;
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk); sticky_clr = 1'b0;
    n_chk++; if (sticky_flags !== exp3) $display("FAIL sticky_clr got=%b exp=%b", sticky_flags, exp3); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_chk, n_pass);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_stream("b2b", 12, 100, 100);
    test_stream("rand", 40, 70, 50);
    test_backpressure();
    test_reset_mid();
    test_sticky();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-driven controller that sequences the shared 4-bit combinational ALU (A, B, SEL in; result, carry, overflow, zero, sign out).
- Buffers operation requests in a small FIFO and issues them one at a time to the ALU.
- Captures the result and flags into a response register with a valid/ready handshake.
- Keeps a 4-bit accumulator so results can be chained into the next operation without the host re-supplying them.

Parameters:
- CMD_DEPTH, 2, command FIFO depth in entries; power of two, >= 2.
- ACC_INIT, 4'h0, accumulator value loaded on reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_sel  input  3  ALU operation select.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_use_acc  input  1  1 = replace operand A with accumulator at issue time.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_sel  output  3  registered select to the ALU.
- alu_res  input  4  ALU result.
- alu_carry  input  1  ALU carry out.
- alu_ovf  input  1  ALU overflow.
- alu_zero  input  1  ALU zero.
- alu_sign  input  1  ALU sign.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  4  captured result.
- rsp_flags  output  4  {sign, zero, ovf, carry}.
- acc  output  4  current accumulator.
- busy  output  1  state != IDLE or FIFO non-empty.
- sticky_clr  input  1  clears sticky flags; used only with the optional feature.
- sticky_flags  output  2  {ovf, carry} sticky flags; optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; state IDLE; acc = ACC_INIT.
  - alu_a, alu_b, alu_sel, rsp_data, rsp_flags, sticky_flags all 0.
  - rsp_valid = 0; busy = 0; cmd_ready = 1 once released.
- Reset mid-operation discards FIFO contents and any pending response. No response is emitted.
- Push: cmd_valid && cmd_ready at a rising edge writes {sel, a, b, use_acc} at the write pointer.
  - cmd_ready = !full.
  - Pointers wrap modulo CMD_DEPTH; an extra bit distinguishes full from empty.
  - No same-cycle pass-through when full.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop head at the edge. Load alu_sel = sel, alu_b = b, alu_a = (use_acc ? acc : a). Go to EXEC.
  - EXEC: exactly one cycle for the ALU to settle. At the edge:
    - rsp_data <= alu_res.
    - rsp_flags <= {alu_sign, alu_zero, alu_ovf, alu_carry}.
    - acc <= alu_res.
    - rsp_valid <= 1.
    - Go to RESP.
  - RESP: hold rsp_data, rsp_flags and rsp_valid stable until rsp_ready=1 at an edge. On that edge, rsp_valid <= 0.
    - If the FIFO is non-empty on that edge, pop and load the ALU registers in the same edge, going directly to EXEC.
    - Otherwise go to IDLE.
- Latency:
  - Command pushed at edge N into an empty, idle block: popped at N+1, rsp_valid high after edge N+2.
  - Back-to-back with rsp_ready held 1: one response every 2 cycles.
- Push and pop in the same cycle are allowed when not full; the occupancy count is unchanged.
- Accumulator chaining: use_acc samples acc at the pop edge, so it sees the result of the previous captured command.
- alu_a, alu_b and alu_sel keep their last values outside EXEC.
- Widths:
  - All operand and result paths are 4 bits.
  - The controller performs no arithmetic on data.
  - Flags are passed through unmodified.

Optional Feature:
- ALU_CTRL_STICKY_EN defined:
  - At each EXEC capture: sticky_flags <= sticky_flags | {alu_ovf, alu_carry}.
  - sticky_clr=1 at an edge without a capture clears sticky_flags to 0.
  - If sticky_clr and a capture coincide, the result is {alu_ovf, alu_carry} of that capture. Clear first, new events win.
- Undefined: sticky_flags tied to 2'b00; sticky_clr ignored. Port list is identical in both builds.

Test Plan:
- Reset then single command sel=add (3'b000), a=4'h7, b=4'h9, rsp_ready=1:
  - alu_a=7, alu_b=9 one cycle after push; rsp_valid two cycles after push.
  - rsp_data=4'h0, rsp_flags carry=1, zero=1; acc=0.
- Chaining: cmd1 a=3,b=4 add; cmd2 use_acc=1, b=1 add:
  - cmd2 drives alu_a=7; second response rsp_data=8; acc=8.
- Backpressure with CMD_DEPTH=2 and rsp_ready=0:
  - Push 4 commands: first pops into EXEC/RESP, next two fill the FIFO, cmd_ready=0 while the 4th is offered.
  - rsp_data stays stable while waiting.
  - Raise rsp_ready: all 4 complete in order, one per 2 cycles, with no loss or duplication.
- Reset pulse while in RESP with 2 entries queued:
  - rsp_valid=0 and busy=0 immediately (async); acc=ACC_INIT.
  - No response is emitted after release.
- With ALU_CTRL_STICKY_EN:
  - Overflow-producing command then a clean command: sticky_flags[1]=1 persists.
  - sticky_clr coincident with a carry-producing capture: sticky_flags=2'b01.
  - Without the macro: sticky_flags=0 throughout.
